// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 responder: frame states, protocol widths
// and the differential-pair channel helper.
// Purely declarative; no logic, no latency, no flow control.
package mcp3008_pkg;

  localparam int DATA_W   = 10;
  localparam int NUM_CH   = 8;
  localparam int CMD_BITS = 4;   // SGL/DIFF, D2, D1, D0

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CMD,
    ST_NULL,
    ST_DATA,
    ST_TRAIL
  } state_t;

  // In differential mode the code selects IN+ directly; IN- is the other
  // member of the same pair, i.e. the code with D0 inverted.
  function automatic logic [2:0] diff_neg_ch(input logic [2:0] code);
    return {code[2:1], ~code[0]};
  endfunction

endpackage

// File: rtl/mcp3008_responder_sync_edge.sv
// Multi-flop synchronizer for one async pin plus registered rise/fall pulses.
// Latency: level after STAGES clk, rise/fall pulses after STAGES+1 clk.
// No backpressure: pulses are single-cycle and must be consumed when seen.
// Ports: clk/rst, async_in (raw pin), level (synchronized), rise, fall.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  assign level = chain[STAGES-1];

  // Chain resets to 0 for every pin: a CS that is still low after reset
  // produces no edge, so a fresh CS fall is required to open a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI responder serving 10-bit samples from ch_data.
// Latency: pin edge -> event SYNC_STAGES+1 clk, dout update one clk later.
// No backpressure: the SPI controller paces the frame via sclk/cs_n.
// Ports: clk/rst; sclk, cs_n, din (async SPI pins); ch_data (8 x 10-bit bank);
//        dout/dout_oe (serial out + pad enable); conv_valid/conv_single/
//        conv_ch (latched command); frame_abort (CS raised mid-transaction).
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 10,
  parameter int NUM_CH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     din,
  input  logic [DATA_W*NUM_CH-1:0] ch_data,
  output logic                     dout,
  output logic                     dout_oe,
  output logic                     conv_valid,
  output logic                     conv_single,
  output logic [2:0]               conv_ch,
  output logic                     frame_abort
);

  import mcp3008_pkg::*;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic din_s, din_rise, din_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .async_in(cs_n),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst(rst), .async_in(din),
    .level(din_s), .rise(din_rise), .fall(din_fall)
  );

  // Only edges of sclk/cs_n and the level of din are needed.
  logic unused_sync;
  assign unused_sync = ^{sclk_s, cs_s, din_rise, din_fall};

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [2:0]        cmd_sr;    // SGL, D2, D1 while waiting for D0
  logic [DATA_W-1:0] shreg;

  // Result as it would be latched on the D0 rise: D0 is the live din_s.
  logic [DATA_W-1:0] ch_arr [NUM_CH];
  logic [2:0]        cmd_code;
  logic              cmd_sgl;
  logic [DATA_W-1:0] pos_val, neg_val, result;

  assign cmd_sgl  = cmd_sr[2];
  assign cmd_code = {cmd_sr[1:0], din_s};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    pos_val = ch_arr[cmd_code];
    neg_val = ch_arr[diff_neg_ch(cmd_code)];
    if (cmd_sgl)
      result = pos_val;
    else if (pos_val >= neg_val)
      result = pos_val - neg_val;
    else
      result = '0;   // negative differential clamps, never wraps
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      shreg       <= '0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_valid  <= 1'b0;
      conv_single <= 1'b0;
      conv_ch     <= '0;
      frame_abort <= 1'b0;
    end else begin
      conv_valid  <= 1'b0;
      frame_abort <= 1'b0;

      // CS release has priority over any coincident sclk edge.
      if (cs_rise) begin
        if (state == ST_CMD || state == ST_NULL || state == ST_DATA)
          frame_abort <= 1'b1;
        state   <= ST_IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            dout    <= 1'b0;
            dout_oe <= 1'b0;
            if (cs_fall)
              state <= ST_WAIT_START;
          end

          ST_WAIT_START: begin
            if (sclk_rise && din_s) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= {cmd_sr[1:0], din_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(CMD_BITS-1)) begin
                conv_single <= cmd_sgl;
                conv_ch     <= cmd_code;
                conv_valid  <= 1'b1;
                shreg       <= result;   // frame is immune to later ch_data
                state       <= ST_NULL;
              end
            end
          end

          ST_NULL: begin
            if (sclk_fall) begin
              dout_oe <= 1'b1;
              dout    <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (sclk_fall) begin
              dout    <= shreg[DATA_W-1];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(DATA_W-1))
                state <= ST_TRAIL;
            end
          end

          ST_TRAIL: begin
            // B0 stays on the line for its full bit time, then zeros.
            if (sclk_fall)
              dout <= 1'b0;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
